// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: shared constants and the queue slot type.
// Ports: none (package).
package fetch_prefetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } slot_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: decode-side and imem-side signals of fetch.
// master = fetch unit, slave = core/memory environment.
interface fetch_prefetch_unit_if;
    import fetch_prefetch_unit_pkg::*;

    logic            stall;
    logic            pc_sel;
    logic [XLEN-1:0] pc_nxt;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_out;
    logic            valid;

    modport master (
        input  stall, pc_sel, pc_nxt,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output instruction, pc_out, valid
    );

    modport slave (
        output stall, pc_sel, pc_nxt,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  instruction, pc_out, valid
    );

endinterface

// File: rtl/fetch_prefetch_unit_queue.sv
// fetch_prefetch_unit_queue: prefetch slots with head/tail/fill pointers.
// Ports: flush_i, alloc_i/alloc_pc_i, fill_i/fill_data_i, pop_i -> count_o, head_*_o.
module fetch_prefetch_unit_queue
    import fetch_prefetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic [CW-1:0]   count_o,
    output logic            head_valid_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [XLEN-1:0] head_pc_o
);

    slot_t slot_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // fill_q always trails tail_q: it points at the oldest
    // allocated slot whose read has not returned yet.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else begin
            if (alloc_i) tail_d = tail_q + PW'(1);
            if (fill_i)  fill_d = fill_q + PW'(1);
            if (pop_i)   head_d = head_q + PW'(1);
            cnt_d = cnt_q + CW'(alloc_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    // Stale filled bits after a flush are harmless: cnt_q gates
    // validity and every slot is re-cleared when re-allocated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (alloc_i) begin
                slot_q[tail_q].pc     <= alloc_pc_i;
                slot_q[tail_q].filled <= 1'b0;
            end
            if (fill_i) begin
                slot_q[fill_q].instr  <= fill_data_i;
                slot_q[fill_q].filled <= 1'b1;
            end
        end
    end

    assign count_o      = cnt_q;
    assign head_valid_o = (cnt_q != '0) && slot_q[head_q].filled;
    assign head_instr_o = slot_q[head_q].instr;
    assign head_pc_o    = slot_q[head_q].pc;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: in-order prefetching fetch stage with redirect flush.
// Ports: clk, rst (async, active-low), bus (master: decode + imem handshake).
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter  int              DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    localparam int              CW       = $clog2(DEPTH) + 1,
    localparam int              OW       = CW + 3
) (
    input logic                   clk,
    input logic                   rst,
    fetch_prefetch_unit_if.master bus
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [OW-1:0]   os_q, os_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   count;
    logic            head_valid;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;

    logic issue;
    logic hs;
    logic drop;
    logic fill;
    logic pop;

    // os_q counts every read still owed by memory, including
    // ones already marked for dropping after a redirect.
    always_comb begin
        issue = rst && (count < FULL) && !bus.pc_sel;
        hs    = issue && bus.imem_gnt;
        drop  = bus.imem_rvalid && (drop_q != '0);
        fill  = bus.imem_rvalid && !drop && !bus.pc_sel;
        pop   = head_valid && !bus.stall && !bus.pc_sel;
        os_d  = os_q + OW'(hs) - OW'(bus.imem_rvalid);
        if (bus.pc_sel) begin
            fpc_d  = word_align(bus.pc_nxt);
            drop_d = os_q - OW'(bus.imem_rvalid);
        end else begin
            fpc_d  = hs ? fpc_q + 32'd4 : fpc_q;
            drop_d = drop_q - OW'(drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q  <= RESET_PC;
            os_q   <= '0;
            drop_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            os_q   <= os_d;
            drop_q <= drop_d;
        end
    end

    fetch_prefetch_unit_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (bus.pc_sel),
        .alloc_i      (hs),
        .alloc_pc_i   (fpc_q),
        .fill_i       (fill),
        .fill_data_i  (bus.imem_rdata),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fpc_q;
    assign bus.valid       = head_valid;
    assign bus.pc_out      = head_pc;
    assign bus.instruction = head_valid ? head_instr : NOP_INSTR;

    a_rvalid_owed : assert property (
        @(posedge clk) disable iff (!rst)
        bus.imem_rvalid |-> (os_q != '0)
    ) else $error("imem_rvalid with no read outstanding");

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: randomized bench with a stream-level reference model.
// Ports: none.
module tb_fetch_prefetch_unit;
    import fetch_prefetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct {
        logic [31:0] a;
        int          ep;
        int          rdy;
    } rq_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;
    int lat   = 1;

    // Model: the expected fetch stream of the current epoch.
    logic [31:0] m_fpc, m_opc;
    int          m_iss, m_fil, m_con;
    rq_t         pend[$];

    logic        e_req, e_valid, r_fire;
    logic [31:0] e_addr, e_pc, e_ins;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if bus ();

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic step(input logic st, input logic sel,
                        input logic [31:0] tg, input logic g,
                        input int rpct);
        @(negedge clk);
        bus.stall  = st;
        bus.pc_sel = sel;
        bus.pc_nxt = tg;
        bus.imem_gnt = g;
        r_fire = 1'b0;
        if (pend.size() > 0) begin
            if (pend[0].rdy <= cyc &&
                int'($urandom_range(99)) < rpct)
                r_fire = 1'b1;
        end
        bus.imem_rvalid = r_fire;
        bus.imem_rdata  = $urandom;
        if (r_fire) bus.imem_rdata = memf(pend[0].a);
        e_req   = ((m_iss - m_con) < DEPTH) && !sel;
        e_addr  = m_fpc;
        e_valid = m_fil > m_con;
        e_pc    = m_opc;
        e_ins   = e_valid ? memf(m_opc) : NOP_INSTR;
        #1;
    endtask

    task automatic advance();
        logic pop, hs;
        pop = e_valid && !bus.stall && !bus.pc_sel;
        hs  = e_req && bus.imem_gnt;
        @(posedge clk);
        if (r_fire) begin
            if (pend[0].ep == epoch) m_fil++;
            void'(pend.pop_front());
        end
        if (bus.pc_sel) begin
            epoch++;
            m_fpc = {bus.pc_nxt[31:2], 2'b00};
            m_opc = m_fpc;
            m_iss = 0;
            m_fil = 0;
            m_con = 0;
        end else begin
            if (hs) begin
                pend.push_back('{a: m_fpc, ep: epoch, rdy: cyc + lat});
                m_iss++;
                m_fpc += 32'd4;
            end
            if (pop) begin
                m_con++;
                m_opc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 0; bus.pc_sel = 0; bus.pc_nxt = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        pend.delete();
        epoch++;
        m_fpc = RPC; m_opc = RPC;
        m_iss = 0; m_fil = 0; m_con = 0;
        r_fire = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.imem_gnt = 1'b1;
        #1;
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_req got %b want 0", bus.imem_req);
        end
        total++;
        if (bus.imem_addr !== RPC) begin
            bad++; $display("FAIL rst_addr got %h want %h", bus.imem_addr, RPC);
        end
        total++;
        if (bus.instruction !== NOP_INSTR) begin
            bad++; $display("FAIL rst_ins got %h want 13", bus.instruction);
        end
        total++;
        if (bus.pc_out !== 32'h0) begin
            bad++; $display("FAIL rst_pc got %h want 0", bus.pc_out);
        end
        total++;
        if (bus.valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got %b want 0", bus.valid);
        end
        do_reset();
    endtask

    task automatic test_stream();
        logic [31:0] wa, wp;
        do_reset();
        lat = 1;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 1, 100);
            wa = RPC + 32'(4 * k);
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== wa) begin
                bad++;
                $display("FAIL stream_addr k=%0d got %b/%h want 1/%h",
                         k, bus.imem_req, bus.imem_addr, wa);
            end
            total++;
            if (bus.valid !== 1'(k >= 2)) begin
                bad++;
                $display("FAIL stream_valid k=%0d got %b", k, bus.valid);
            end
            if (k >= 2) begin
                wp = RPC + 32'(4 * (k - 2));
                total++;
                if (bus.pc_out !== wp || bus.instruction !== memf(wp)) begin
                    bad++;
                    $display("FAIL stream_pc k=%0d got %h/%h want %h/%h",
                             k, bus.pc_out, bus.instruction, wp, memf(wp));
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = m_opc;
        for (int s = 0; s < 5; s++) begin
            step(1, 0, 0, 1, 100);
            total++;
            if (bus.valid !== 1'b1 || bus.pc_out !== held) begin
                bad++;
                $display("FAIL stall_hold s=%0d got %b/%h want 1/%h",
                         s, bus.valid, bus.pc_out, held);
            end
            total++;
            if (bus.imem_req !== e_req || (s >= 2 && bus.imem_req !== 1'b0)) begin
                bad++;
                $display("FAIL stall_req s=%0d got %b want %b",
                         s, bus.imem_req, e_req);
            end
            advance();
        end
        for (int s = 0; s < 6; s++) begin
            step(0, 0, 0, 1, 100);
            total++;
            if (bus.imem_req !== e_req || bus.imem_addr !== e_addr ||
                bus.valid !== e_valid || bus.pc_out !== e_pc) begin
                bad++;
                $display("FAIL stall_resume s=%0d got %b/%h/%b/%h want %b/%h/%b/%h",
                         s, bus.imem_req, bus.imem_addr, bus.valid, bus.pc_out,
                         e_req, e_addr, e_valid, e_pc);
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        logic seen;
        do_reset();
        lat = 3;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 100);
            advance();
        end
        step(0, 1, 32'h100, 1, 0);
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL redir_req got %b want 0", bus.imem_req);
        end
        advance();
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(0, 0, 0, 1, 100);
            total++;
            if (bus.valid !== e_valid) begin
                bad++;
                $display("FAIL redir_valid k=%0d got %b want %b",
                         k, bus.valid, e_valid);
            end
            if (bus.valid === 1'b1) begin
                seen = 1'b1;
                total++;
                if (bus.pc_out !== 32'h100 || bus.instruction !== memf(32'h100)) begin
                    bad++;
                    $display("FAIL redir_first got %h/%h want 100/%h",
                             bus.pc_out, bus.instruction, memf(32'h100));
                end
            end
            advance();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL redir_timeout got no valid want pc 100");
        end
    endtask

    task automatic test_redirect_rvalid();
        logic seen;
        do_reset();
        lat = 2;
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 1, 100);
            advance();
        end
        step(0, 1, 32'h203, 1, 100);
        total++;
        if (r_fire !== 1'b1 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL redrv_setup got fire=%b req=%b want 1/0",
                     r_fire, bus.imem_req);
        end
        advance();
        lat = 1;
        step(0, 0, 0, 1, 100);
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            bad++;
            $display("FAIL redrv_addr got %b/%h want 1/200",
                     bus.imem_req, bus.imem_addr);
        end
        advance();
        seen = 1'b0;
        for (int k = 0; k < 15 && !seen; k++) begin
            step(0, 0, 0, 1, 100);
            if (bus.valid === 1'b1) begin
                seen = 1'b1;
                total++;
                if (bus.pc_out !== 32'h200 || bus.instruction !== memf(32'h200)) begin
                    bad++;
                    $display("FAIL redrv_first got %h/%h want 200/%h",
                             bus.pc_out, bus.instruction, memf(32'h200));
                end
            end
            advance();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL redrv_timeout got no valid want pc 200");
        end
    endtask

    task automatic test_gnt_low();
        do_reset();
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 100);
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC ||
                bus.valid !== 1'b0 || bus.instruction !== NOP_INSTR) begin
                bad++;
                $display("FAIL gnt_low k=%0d got %b/%h/%b/%h want 1/%h/0/13",
                         k, bus.imem_req, bus.imem_addr, bus.valid,
                         bus.instruction, RPC);
            end
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 100);
            total++;
            if (bus.imem_addr !== e_addr) begin
                bad++;
                $display("FAIL gnt_resume k=%0d got %h want %h",
                         k, bus.imem_addr, e_addr);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1, 100);
            advance();
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== RPC ||
            bus.instruction !== NOP_INSTR || bus.pc_out !== 32'h0 ||
            bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got %b/%h/%h/%h/%b want 0/%h/13/0/0",
                     bus.imem_req, bus.imem_addr, bus.instruction,
                     bus.pc_out, bus.valid, RPC);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic st, sel, g;
        logic [31:0] tg;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            lat = int'($urandom_range(4, 1));
            st  = ($urandom_range(99) < 30);
            sel = ($urandom_range(99) < 3);
            tg  = $urandom;
            g   = ($urandom_range(99) < 70) && (pend.size() < 2 * DEPTH);
            step(st, sel, tg, g, 60);
            total++;
            if (bus.imem_req !== e_req || bus.imem_addr !== e_addr) begin
                bad++;
                $display("FAIL rnd_issue c=%0d got %b/%h want %b/%h",
                         cyc, bus.imem_req, bus.imem_addr, e_req, e_addr);
            end
            total++;
            if (bus.valid !== e_valid || bus.instruction !== e_ins) begin
                bad++;
                $display("FAIL rnd_out c=%0d got %b/%h want %b/%h",
                         cyc, bus.valid, bus.instruction, e_valid, e_ins);
            end
            if (e_valid) begin
                total++;
                if (bus.pc_out !== e_pc) begin
                    bad++;
                    $display("FAIL rnd_pc c=%0d got %h want %h",
                             cyc, bus.pc_out, e_pc);
                end
            end
            advance();
        end
    endtask

    initial begin
        bus.stall = 0; bus.pc_sel = 0; bus.pc_nxt = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        m_fpc = RPC; m_opc = RPC;
        m_iss = 0; m_fil = 0; m_con = 0;
        r_fire = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_gnt_low();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
